// File: rtl/alu32_arbiter.sv
// -----------------------------------------------------------------------------
// alu32_arbiter
//
// Purpose:
//    Shares one external combinational ALU between two requesters. A winner is
//    chosen in IDLE, its opcode/operands are registered onto the ALU inputs,
//    the controller waits ALU_LAT settle cycles, captures the ALU output and
//    returns it with a one-cycle done pulse to the requester that was granted.
//    State sequence: IDLE -> EXEC -> DONE -> IDLE, one operation in flight.
//
// Parameters:
//    WIDTH    operand/result width
//    OPW      opcode width (opcode is passed through, never decoded)
//    ALU_LAT  settle cycles between driving the ALU and capturing alu_s (1..15)
//
// Ports:
//    clk, reset           clock (rising edge), synchronous active-high reset
//    req0/op0/a0/b0       requester 0 request, opcode, operands
//    req1/op1/a1/b1       requester 1 request, opcode, operands
//    gnt0, gnt1           1-cycle pulse: operation accepted (IDLE cycle)
//    done0, done1         1-cycle pulse: result valid for that requester
//    result, zero         captured ALU result and result==0 flag
//    busy                 high while in EXEC or DONE
//    alu_op/alu_a/alu_b   registered ALU inputs
//    alu_s                ALU combinational result
//
// Configuration:
//    ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie.
//                           undefined (default): round-robin on ties.
// -----------------------------------------------------------------------------
module alu32_arbiter #(
   parameter int WIDTH   = 32,
   parameter int OPW     = 3,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [OPW-1:0]   op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [OPW-1:0]   op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_s
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // The settle counter is loaded with ALU_LAT-1 so that capture happens in
   // the ALU_LAT-th EXEC cycle.
   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             owner_q, owner_d;    // 1 = requester 1 owns the op in flight
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             pick1;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Requester 0 always wins; requester 1 only gets through when req0 is low.
   assign pick1 = req1 & ~req0;
`else
   logic             last_gnt_q, last_gnt_d;

   // On a tie the requester that was not granted last time wins.
   assign pick1 = req1 & (~req0 | ~last_gnt_q);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      alu_op_d = alu_op_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      result_d = result_q;
      zero_d   = zero_q;
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      done0    = 1'b0;
      done1    = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_gnt_d = last_gnt_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               owner_d  = pick1;
               alu_op_d = pick1 ? op1 : op0;
               alu_a_d  = pick1 ? a1  : a0;
               alu_b_d  = pick1 ? b1  : b0;
               cnt_d    = CNT_INIT;
               gnt0     = ~pick1;
               gnt1     = pick1;
               state_d  = S_EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
               last_gnt_d = pick1;
`endif
            end
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) begin
               result_d = alu_s;
               zero_d   = (alu_s == '0);
               state_d  = S_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            done0   = ~owner_q;
            done1   = owner_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Reset suppresses every handshake pulse in the cycle it is asserted.
      if (reset) begin
         gnt0  = 1'b0;
         gnt1  = 1'b0;
         done0 = 1'b0;
         done1 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         owner_q  <= 1'b0;
         alu_op_q <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

`ifndef ALU_ARB_FIXED_PRIO_EN
   // Starts at 1 so requester 0 wins the first tie after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end
`endif

   assign busy   = (state_q != S_IDLE);
   assign result = result_q;
   assign zero   = zero_q;
   assign alu_op = alu_op_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu32_arbiter
//
// Bench for alu32_arbiter. Supplies a behavioural ALU to two instances
// (ALU_LAT=1 and ALU_LAT=3), applies a table of single operations, tie and
// reset corner sequences, then randomized traffic checked against a
// transaction-level model (grant rule, completion time, expected result).
// -----------------------------------------------------------------------------
module tb_alu32_arbiter;

   localparam int W   = 32;
   localparam int OW  = 3;
   localparam int LAT = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main instance (ALU_LAT = 1) ----------------
   logic          reset;
   logic          req0, req1;
   logic [OW-1:0] op0, op1;
   logic [W-1:0]  a0, b0, a1, b1;
   logic          gnt0, gnt1, done0, done1, zero, busy;
   logic [W-1:0]  result, alu_a, alu_b, alu_s;
   logic [OW-1:0] alu_op;

   // ---------------- second instance (ALU_LAT = 3) ----------------
   logic          l_req0, l_req1;
   logic [OW-1:0] l_op0, l_op1;
   logic [W-1:0]  l_a0, l_b0, l_a1, l_b1;
   logic          l_gnt0, l_gnt1, l_done0, l_done1, l_zero, l_busy;
   logic [W-1:0]  l_result, l_alu_a, l_alu_b, l_alu_s;
   logic [OW-1:0] l_alu_op;

   function automatic logic [W-1:0] alu_fn(input logic [OW-1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b100:  return ~(a | b);
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_s   = alu_fn(alu_op, alu_a, alu_b);
   assign l_alu_s = alu_fn(l_alu_op, l_alu_a, l_alu_b);

   alu32_arbiter #(.WIDTH(W), .OPW(OW), .ALU_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .zero(zero), .busy(busy),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s)
   );

   alu32_arbiter #(.WIDTH(W), .OPW(OW), .ALU_LAT(3)) dut3 (
      .clk(clk), .reset(reset),
      .req0(l_req0), .op0(l_op0), .a0(l_a0), .b0(l_b0),
      .req1(l_req1), .op1(l_op1), .a1(l_a1), .b1(l_b1),
      .gnt0(l_gnt0), .gnt1(l_gnt1), .done0(l_done0), .done1(l_done1),
      .result(l_result), .zero(l_zero), .busy(l_busy),
      .alu_op(l_alu_op), .alu_a(l_alu_a), .alu_b(l_alu_b), .alu_s(l_alu_s)
   );

`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drive(input bit who, input logic r, input logic [OW-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      if (who) begin
         req1 = r; op1 = op; a1 = a; b1 = b;
      end else begin
         req0 = r; op0 = op; a0 = a; b0 = b;
      end
   endtask

   // One complete operation on the ALU_LAT=1 instance starting in an IDLE cycle.
   task automatic do_op(input string nm, input bit who, input logic [OW-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ez);
      drive(who, 1'b1, op, a, b);
      smp();
      chk({nm, ".gnt"},   who ? gnt1 : gnt0, 1);
      chk({nm, ".gnt_o"}, who ? gnt0 : gnt1, 0);
      chk({nm, ".busy0"}, busy, 0);
      cyc();
      drive(who, 1'b1, ~op, ~a, ~b);       // operands may change after grant
      smp();
      chk({nm, ".busy1"}, busy, 1);
      chk({nm, ".nodone"}, {done1, done0}, 0);
      chk({nm, ".alu_a"}, alu_a, a);
      chk({nm, ".alu_b"}, alu_b, b);
      chk({nm, ".alu_op"}, alu_op, op);
      cyc();
      smp();
      chk({nm, ".done"},   who ? done1 : done0, 1);
      chk({nm, ".done_o"}, who ? done0 : done1, 0);
      chk({nm, ".result"}, result, er);
      chk({nm, ".zero"},   zero, ez);
      cyc();
      drive(who, 1'b0, '0, '0, '0);
   endtask

   typedef struct {
      string         nm;
      bit            who;
      logic [OW-1:0] op;
      logic [W-1:0]  a, b, res;
      logic          z;
   } vec_t;

   vec_t tv[8];

   // randomized-phase model state
   logic          rq[2];
   logic [OW-1:0] rop[2];
   logic [W-1:0]  ra[2], rb[2];

   task automatic rnd_op(input int i);
      rq[i]  = 1'b1;
      rop[i] = OW'($urandom_range(0, 7));
      ra[i]  = $urandom;
      rb[i]  = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            g_who[$];
      int            g_cyc[$];
      logic [W-1:0]  s3;
      int            next_free, done_cyc, gnt_cyc, last;
      bit            done_who, w;
      logic [W-1:0]  exp_res;
      logic          eg0, eg1;

      tv[0] = '{"nor",   1'b0, 3'b100, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0};
      tv[1] = '{"addc",  1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
      tv[2] = '{"and",   1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
      tv[3] = '{"or",    1'b1, 3'b001, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
      tv[4] = '{"sub",   1'b0, 3'b110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
      tv[5] = '{"slt1",  1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
      tv[6] = '{"slt0",  1'b0, 3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      tv[7] = '{"subov", 1'b1, 3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0};

      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      l_req0 = 1'b0; l_op0 = '0; l_a0 = '0; l_b0 = '0;
      l_req1 = 1'b0; l_op1 = '0; l_a1 = '0; l_b1 = '0;
      cyc();
      cyc();
      smp();
      chk("rst.gnt",    {gnt1, gnt0}, 0);
      chk("rst.done",   {done1, done0}, 0);
      chk("rst.busy",   busy, 0);
      chk("rst.result", result, 0);
      chk("rst.zero",   zero, 0);
      chk("rst.alu_op", alu_op, 0);
      chk("rst.alu_a",  alu_a, 0);
      chk("rst.alu_b",  alu_b, 0);
      cyc();
      reset = 1'b0;

      // ---------------- table of single operations ----------------
      for (int i = 0; i < 8; i++) begin
         do_op(tv[i].nm, tv[i].who, tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].z);
      end

      // ---------------- both requesting for 4 operations ----------------
      // last grant was requester 1, so the first tie goes to requester 0
      drive(1'b0, 1'b1, 3'b010, 32'd1, 32'd2);
      drive(1'b1, 1'b1, 3'b001, 32'd4, 32'd8);
      for (int k = 0; k < 12; k++) begin
         smp();
         chk("tie.gnt_excl",  gnt0 & gnt1, 0);
         chk("tie.done_excl", done0 & done1, 0);
         if (gnt0 | gnt1) begin
            g_who.push_back(int'(gnt1));
            g_cyc.push_back(k);
         end
         cyc();
      end
      chk("tie.count", 32'(g_who.size()), 4);
      for (int i = 0; i < g_who.size() && i < 4; i++) begin
         chk($sformatf("tie.who%0d", i), 32'(g_who[i]), FIXED ? 0 : (i % 2));
         chk($sformatf("tie.cyc%0d", i), 32'(g_cyc[i]), 32'(3 * i));
      end
      drive(1'b0, 1'b0, '0, '0, '0);        // requester 0 leaves; 1 must get in
      smp();
      chk("tie.r1_gnt", {gnt1, gnt0}, 2'b10);
      cyc();
      cyc();
      smp();
      chk("tie.r1_done", {done1, done0}, 2'b10);
      chk("tie.r1_res",  result, 32'h0000000C);
      cyc();
      drive(1'b1, 1'b0, '0, '0, '0);

      // ---------------- reset during EXEC ----------------
      drive(1'b0, 1'b1, 3'b010, 32'h11111111, 32'h22222222);
      smp();
      chk("rexec.gnt0", gnt0, 1);
      cyc();
      reset = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      smp();
      chk("rexec.busy", busy, 1);
      cyc();
      reset = 1'b0;
      smp();
      chk("rexec.done",   {done1, done0}, 0);
      chk("rexec.gnt",    {gnt1, gnt0}, 0);
      chk("rexec.busy0",  busy, 0);
      chk("rexec.result", result, 0);
      chk("rexec.zero",   zero, 0);
      chk("rexec.alu",    alu_a | alu_b | W'(alu_op), 0);
      cyc();
      smp();
      chk("rexec.nodone", {done1, done0}, 0);
      cyc();
      drive(1'b0, 1'b1, 3'b000, 32'hFFFF0000, 32'h0FF00FF0);
      drive(1'b1, 1'b1, 3'b001, 32'h0, 32'h0);
      smp();
      chk("rexec.tie", {gnt1, gnt0}, 2'b01);
      cyc();
      cyc();
      smp();
      chk("rexec.tie_done", {done1, done0}, 2'b01);
      chk("rexec.tie_res",  result, 32'h0FF00000);

      // ---------------- ALU_LAT = 3 instance ----------------
      cyc();
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      l_req0 = 1'b1; l_op0 = 3'b010; l_a0 = 32'h7FFFFFFF; l_b0 = 32'h00000001;
      smp();
      chk("lat3.gnt0", l_gnt0, 1);
      s3 = '0;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         l_a0 = $urandom; l_b0 = $urandom;
         smp();
         chk($sformatf("lat3.busy%0d", k),  l_busy, 1);
         chk($sformatf("lat3.a%0d", k),     l_alu_a, 32'h7FFFFFFF);
         chk($sformatf("lat3.b%0d", k),     l_alu_b, 32'h00000001);
         chk($sformatf("lat3.nodn%0d", k),  l_done0, 0);
         if (k == 3) s3 = l_alu_s;
      end
      cyc();
      smp();
      chk("lat3.done0", l_done0, 1);
      chk("lat3.res_s", l_result, s3);
      chk("lat3.res",   l_result, 32'h80000000);
      chk("lat3.zero",  l_zero, 0);
      cyc();
      l_req0 = 1'b0;

      // ---------------- randomized traffic ----------------
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      rq[0] = 1'b0; rq[1] = 1'b0;
      rop[0] = '0; rop[1] = '0; ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0;
      next_free = 0; done_cyc = -10; gnt_cyc = -10; last = 1;
      done_who = 1'b0; exp_res = '0;
      for (int c = 0; c < 400; c++) begin
         if (c - 1 == done_cyc) begin
            if ($urandom_range(0, 1) == 0) rq[done_who] = 1'b0;
            else rnd_op(int'(done_who));
         end
         for (int i = 0; i < 2; i++)
            if (!rq[i] && $urandom_range(0, 2) == 0) rnd_op(i);
         drive(1'b0, rq[0], rop[0], ra[0], rb[0]);
         drive(1'b1, rq[1], rop[1], ra[1], rb[1]);

         eg0 = 1'b0; eg1 = 1'b0;
         if (c >= next_free && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) w = FIXED ? 1'b0 : (last == 0);
            else                w = rq[1];
            if (w) eg1 = 1'b1; else eg0 = 1'b1;
            last      = int'(w);
            gnt_cyc   = c;
            done_cyc  = c + LAT + 1;
            next_free = c + LAT + 2;
            done_who  = w;
            exp_res   = alu_fn(rop[w], ra[w], rb[w]);
         end

         smp();
         chk("rnd.gnt",  {gnt1, gnt0}, {eg1, eg0});
         chk("rnd.done", {done1, done0},
             (c == done_cyc) ? (done_who ? 2'b10 : 2'b01) : 2'b00);
         chk("rnd.busy", busy, (c > gnt_cyc && c < next_free) ? 1 : 0);
         if (c == done_cyc) begin
            chk("rnd.result", result, exp_res);
            chk("rnd.zero",   zero, (exp_res == '0) ? 1 : 0);
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
